// File: rtl/bp_be_fe_cmd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_be_fe_cmd_arbiter_pkg
//  Description : Shared types and constants for the BE->FE command arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_be_fe_cmd_arbiter_pkg;

    // Arbiter phases: pick/capture, hold for FE handshake, wait for FE drain.
    typedef enum logic [1:0] {
        e_fca_idle  = 2'd0,
        e_fca_issue = 2'd1,
        e_fca_fence = 2'd2
    } bp_be_fe_cmd_arb_state_e;

    // Director redirect source; always beats the round-robin group.
    localparam int fe_cmd_arb_prio_idx_gp = 0;

endpackage
`default_nettype wire

// File: rtl/bp_be_fe_cmd_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : bp_be_fe_cmd_arb_rr
//  Description : Combinational round-robin picker over requesters 1..N-1.
//                Search starts at rr_ptr and wraps from N-1 back to 1.
//                Requester 0 is never granted here.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_be_fe_cmd_arb_rr #(
    parameter int num_req_p = 4
) (
    input  logic [num_req_p-1:0]         elig,
    input  logic [$clog2(num_req_p)-1:0] rr_ptr,
    output logic [num_req_p-1:0]         grant_oh,
    output logic                         grant_v
);

    localparam int ptr_width_lp = $clog2(num_req_p);

    logic [num_req_p-1:0] ge_ptr;
    logic [num_req_p-1:0] cand;
    logic [num_req_p-1:0] upper;
    logic [num_req_p-1:0] upper_low;
    logic [num_req_p-1:0] any_low;

    // Marks indices at or beyond the round-robin pointer.
    for (genvar i = 0; i < num_req_p; i++) begin : g_ge_ptr
        assign ge_ptr[i] = (ptr_width_lp'(i) >= rr_ptr);
    end

    // Requester 0 belongs to the priority path, not this group.
    assign cand      = elig & {{(num_req_p-1){1'b1}}, 1'b0};
    assign upper     = cand & ge_ptr;

    // Lowest set bit isolates the first candidate in search order; when
    // nothing sits at/after the pointer, wrap to the lowest candidate.
    assign upper_low = upper & (~upper + num_req_p'(1));
    assign any_low   = cand  & (~cand  + num_req_p'(1));

    assign grant_oh  = (|upper) ? upper_low : any_low;
    assign grant_v   = |cand;

endmodule
`default_nettype wire

// File: rtl/bp_be_fe_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bp_be_fe_cmd_arbiter
//  Description : Shares the BE->FE command port among several requesters.
//                Requester 0 (redirect) has strict priority, the rest are
//                served round-robin. The granted command is held until the
//                FE accepts it; serializing commands wait for the FE queue
//                to drain before and after issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_be_fe_cmd_arbiter
    import bp_be_fe_cmd_arbiter_pkg::*;
#(
    parameter int num_req_p   = 4,
    parameter int cmd_width_p = 64
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_req_p*cmd_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]             req_v_i,
    input  logic [num_req_p-1:0]             req_serial_i,
    output logic [num_req_p-1:0]             req_yumi_o,
    input  logic                             flush_i,
    output logic [cmd_width_p-1:0]           fe_cmd_o,
    output logic                             fe_cmd_v_o,
    input  logic                             fe_cmd_ready_i,
    input  logic                             fe_cmd_fence_i,
    output logic                             busy_o,
    output logic [$clog2(num_req_p)-1:0]     grant_id_o
);

    localparam int                       id_width_lp = $clog2(num_req_p);
    localparam logic [id_width_lp-1:0]   prio_id_lp  = id_width_lp'(fe_cmd_arb_prio_idx_gp);
    localparam logic [num_req_p-1:0]     rr_mask_lp  = {{(num_req_p-1){1'b1}}, 1'b0};

    bp_be_fe_cmd_arb_state_e state;
    logic                    serial_r;
    logic [id_width_lp-1:0]  rr_ptr;

    logic [num_req_p-1:0]    elig;
    logic [num_req_p-1:0]    rr_elig;
    logic [num_req_p-1:0]    rr_grant;
    logic                    rr_grant_v;
    logic [num_req_p-1:0]    win_oh;
    logic                    win_v;
    logic [id_width_lp-1:0]  win_idx;
    logic [cmd_width_p-1:0]  win_cmd;
    logic [id_width_lp-1:0]  next_ptr;

    // A serializing command may only start once the FE queue is empty.
    assign elig    = req_v_i & (~req_serial_i | {num_req_p{~fe_cmd_fence_i}});
    // A director flush suppresses everything except the redirect source.
    assign rr_elig = elig & rr_mask_lp & {num_req_p{~flush_i}};

    bp_be_fe_cmd_arb_rr #(
        .num_req_p (num_req_p)
    ) u_rr (
        .elig      (rr_elig),
        .rr_ptr    (rr_ptr),
        .grant_oh  (rr_grant),
        .grant_v   (rr_grant_v)
    );

    // Redirect overrides the round-robin choice whenever it is eligible.
    always_comb begin
        win_oh = rr_grant;
        if (elig[fe_cmd_arb_prio_idx_gp]) begin
            win_oh = '0;
            win_oh[fe_cmd_arb_prio_idx_gp] = 1'b1;
        end
    end

    assign win_v = elig[fe_cmd_arb_prio_idx_gp] | rr_grant_v;

    // One-hot to index encode and command select for the winner.
    always_comb begin
        win_idx = '0;
        win_cmd = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (win_oh[i]) begin
                win_idx = win_idx | id_width_lp'(i);
                win_cmd = win_cmd | req_cmd_i[i*cmd_width_p +: cmd_width_p];
            end
        end
    end

    assign next_ptr   = (win_idx == id_width_lp'(num_req_p-1)) ? id_width_lp'(1)
                                                                : win_idx + id_width_lp'(1);

    // Capture is acknowledged in the same cycle, only while idle.
    assign req_yumi_o = (state == e_fca_idle) ? win_oh : '0;

    // Arbiter FSM with the held command, its source and the round-robin pointer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= e_fca_idle;
            fe_cmd_o   <= '0;
            fe_cmd_v_o <= 1'b0;
            grant_id_o <= '0;
            serial_r   <= 1'b0;
            busy_o     <= 1'b0;
            rr_ptr     <= id_width_lp'(1);
        end else begin
            unique case (state)
                e_fca_idle: begin
                    if (win_v) begin
                        state      <= e_fca_issue;
                        fe_cmd_v_o <= 1'b1;
                        busy_o     <= 1'b1;
                        fe_cmd_o   <= win_cmd;
                        grant_id_o <= win_idx;
                        serial_r   <= |(req_serial_i & win_oh);
                        // The redirect source does not consume a round-robin turn.
                        if (!win_oh[fe_cmd_arb_prio_idx_gp]) begin
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                e_fca_issue: begin
                    // A handshake always completes even if a flush arrives with it.
                    if (fe_cmd_ready_i) begin
                        fe_cmd_v_o <= 1'b0;
                        if (serial_r) begin
                            state  <= e_fca_fence;
                            busy_o <= 1'b1;
                        end else begin
                            state  <= e_fca_idle;
                            busy_o <= 1'b0;
                        end
                    end else if (flush_i && (grant_id_o != prio_id_lp)) begin
                        // Non-redirect command is discarded; its yumi was already given.
                        state      <= e_fca_idle;
                        fe_cmd_v_o <= 1'b0;
                        busy_o     <= 1'b0;
                    end
                end
                e_fca_fence: begin
                    if (!fe_cmd_fence_i) begin
                        state  <= e_fca_idle;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state      <= e_fca_idle;
                    fe_cmd_v_o <= 1'b0;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_yumi_onehot0: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0(req_yumi_o));

    a_yumi_idle_only: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (req_yumi_o != '0) |-> (state == e_fca_idle));

    a_cmd_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (fe_cmd_v_o && !fe_cmd_ready_i) |=> $stable(fe_cmd_o));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_be_fe_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_be_fe_cmd_arbiter
//  Description : Self-checking bench for bp_be_fe_cmd_arbiter: directed
//                scenarios plus randomized traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_be_fe_cmd_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N*W-1:0] req_cmd;
    logic [N-1:0]   req_v;
    logic [N-1:0]   req_serial;
    logic [N-1:0]   req_yumi;
    logic           flush;
    logic [W-1:0]   fe_cmd;
    logic           fe_cmd_v;
    logic           ready;
    logic           fence;
    logic           busy;
    logic [1:0]     grant_id;

    int tests_run    = 0;
    int tests_failed = 0;

    bp_be_fe_cmd_arbiter #(
        .num_req_p      (N),
        .cmd_width_p    (W)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .req_cmd_i      (req_cmd),
        .req_v_i        (req_v),
        .req_serial_i   (req_serial),
        .req_yumi_o     (req_yumi),
        .flush_i        (flush),
        .fe_cmd_o       (fe_cmd),
        .fe_cmd_v_o     (fe_cmd_v),
        .fe_cmd_ready_i (ready),
        .fe_cmd_fence_i (fence),
        .busy_o         (busy),
        .grant_id_o     (grant_id)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic [W-1:0] c);
        req_cmd[i*W +: W] = c;
    endtask

    task automatic clear_inputs();
        req_v      = '0;
        req_serial = '0;
        flush      = 1'b0;
        ready      = 1'b0;
        fence      = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        req_cmd = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // Arbiter behaviour expressed as "is a command held", "is the FE draining",
    // and a search over requester numbers starting at the rotating pointer.
    bit           m_hold;
    bit           m_drain;
    bit           m_serial;
    logic [W-1:0] m_cmd;
    int           m_id;
    int           m_ptr;

    function automatic bit m_ok(input int i);
        return req_v[i] && (!req_serial[i] || !fence);
    endfunction

    function automatic int m_pick();
        if (m_hold || m_drain) return -1;
        if (m_ok(0)) return 0;
        if (flush) return -1;
        for (int k = 0; k < N-1; k++) begin
            int i;
            i = 1 + ((m_ptr - 1 + k) % (N-1));
            if (m_ok(i)) return i;
        end
        return -1;
    endfunction

    task automatic m_step(input int pick);
        if (pick >= 0) begin
            m_hold   = 1'b1;
            m_cmd    = req_cmd[pick*W +: W];
            m_id     = pick;
            m_serial = req_serial[pick];
            if (pick != 0) m_ptr = (pick == N-1) ? 1 : pick + 1;
        end else if (m_hold) begin
            if (ready) begin
                m_hold  = 1'b0;
                m_drain = m_serial;
            end else if (flush && m_id != 0) begin
                m_hold = 1'b0;
            end
        end else if (m_drain) begin
            if (!fence) m_drain = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (fe_cmd !== '0 || grant_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_regs: cmd=%h id=%0d, want 0/0", fe_cmd, grant_id);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests_run++;
            if (fe_cmd_v !== 1'b0 || busy !== 1'b0 || req_yumi !== 4'b0) begin
                tests_failed++;
                $display("FAIL reset_idle c=%0d: v=%b busy=%b yumi=%b, want 0/0/0000", c, fe_cmd_v, busy, req_yumi);
            end
        end
        tick();
    endtask

    task automatic test_round_robin();
        int ids [4] = '{1, 2, 3, 1};
        set_cmd(1, 64'h11); set_cmd(2, 64'h22); set_cmd(3, 64'h33);
        req_v = 4'b1110;
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] ec;
            ec = W'(ids[k] * 'h11);
            @(negedge clk);
            tests_run++;
            if (req_yumi !== 4'(1 << ids[k]) || fe_cmd_v !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_grant k=%0d: yumi=%b v=%b, want %b v=0", k, req_yumi, fe_cmd_v, 4'(1 << ids[k]));
            end
            tick();
            @(negedge clk);
            tests_run++;
            if (fe_cmd_v !== 1'b1 || fe_cmd !== ec || grant_id !== 2'(ids[k]) || req_yumi !== 4'b0) begin
                tests_failed++;
                $display("FAIL rr_issue k=%0d: v=%b cmd=%h id=%0d yumi=%b, want 1 %h %0d 0000", k, fe_cmd_v, fe_cmd, grant_id, req_yumi, ec, ids[k]);
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_priority();
        apply_reset();
        set_cmd(0, 64'hA0); set_cmd(1, 64'hA1); set_cmd(3, 64'hA3);
        req_v = 4'b1011;
        ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (req_yumi !== 4'b0001) begin
            tests_failed++; $display("FAIL prio_first: yumi=%b, want 0001", req_yumi);
        end
        tick();
        req_v = 4'b1010;
        @(negedge clk);
        tests_run++;
        if (fe_cmd_v !== 1'b1 || fe_cmd !== 64'hA0 || grant_id !== 2'd0) begin
            tests_failed++; $display("FAIL prio_issue: v=%b cmd=%h id=%0d, want 1 a0 0", fe_cmd_v, fe_cmd, grant_id);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (req_yumi !== 4'b0010) begin
            tests_failed++; $display("FAIL prio_then_rr: yumi=%b, want 0010", req_yumi);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (fe_cmd !== 64'hA1 || grant_id !== 2'd1) begin
            tests_failed++; $display("FAIL prio_rr_issue: cmd=%h id=%0d, want a1 1", fe_cmd, grant_id);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (req_yumi !== 4'b1000) begin
            tests_failed++; $display("FAIL prio_ptr_moved: yumi=%b, want 1000", req_yumi);
        end
        tick();
        req_v = 4'b0000;
        tick();
        clear_inputs();
    endtask

    task automatic test_serial_fence();
        set_cmd(2, 64'h2222);
        req_v      = 4'b0100;
        req_serial = 4'b0100;
        fence      = 1'b1;
        ready      = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (req_yumi !== 4'b0 || busy !== 1'b0) begin
                tests_failed++; $display("FAIL serial_blocked c=%0d: yumi=%b busy=%b, want 0000 0", c, req_yumi, busy);
            end
            tick();
        end
        fence = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_yumi !== 4'b0100) begin
            tests_failed++; $display("FAIL serial_granted: yumi=%b, want 0100", req_yumi);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (fe_cmd_v !== 1'b1 || grant_id !== 2'd2) begin
            tests_failed++; $display("FAIL serial_issue: v=%b id=%0d, want 1 2", fe_cmd_v, grant_id);
        end
        tick();
        fence      = 1'b1;
        req_v      = 4'b0001;
        req_serial = 4'b0000;
        set_cmd(0, 64'h0F0F);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (busy !== 1'b1 || fe_cmd_v !== 1'b0 || req_yumi !== 4'b0) begin
                tests_failed++; $display("FAIL fence_hold c=%0d: busy=%b v=%b yumi=%b, want 1 0 0000", c, busy, fe_cmd_v, req_yumi);
            end
            tick();
        end
        fence = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_yumi !== 4'b0 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL fence_exit_wait: yumi=%b busy=%b, want 0000 1", req_yumi, busy);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (req_yumi !== 4'b0001 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL fence_then_grant: yumi=%b busy=%b, want 0001 0", req_yumi, busy);
        end
        tick();
        req_v = 4'b0000;
        @(negedge clk);
        tests_run++;
        if (fe_cmd_v !== 1'b1 || fe_cmd !== 64'h0F0F) begin
            tests_failed++; $display("FAIL fence_next_issue: v=%b cmd=%h, want 1 0f0f", fe_cmd_v, fe_cmd);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_flush();
        set_cmd(2, 64'h5A5A);
        req_v = 4'b0100;
        @(negedge clk);
        tests_run++;
        if (req_yumi !== 4'b0100) begin
            tests_failed++; $display("FAIL flush_setup: yumi=%b, want 0100", req_yumi);
        end
        tick();
        req_v = 4'b0000;
        flush = 1'b1;
        @(negedge clk);
        tests_run++;
        if (fe_cmd_v !== 1'b1 || grant_id !== 2'd2) begin
            tests_failed++; $display("FAIL flush_held: v=%b id=%0d, want 1 2", fe_cmd_v, grant_id);
        end
        tick();
        req_v = 4'b0110;
        @(negedge clk);
        tests_run++;
        if (fe_cmd_v !== 1'b0 || busy !== 1'b0 || req_yumi !== 4'b0) begin
            tests_failed++; $display("FAIL flush_drop: v=%b busy=%b yumi=%b, want 0 0 0000", fe_cmd_v, busy, req_yumi);
        end
        tick();
        req_v = 4'b0111;
        set_cmd(0, 64'hC0DE);
        @(negedge clk);
        tests_run++;
        if (req_yumi !== 4'b0001) begin
            tests_failed++; $display("FAIL flush_prio_served: yumi=%b, want 0001", req_yumi);
        end
        tick();
        req_v = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (fe_cmd_v !== 1'b1 || grant_id !== 2'd0 || fe_cmd !== 64'hC0DE) begin
                tests_failed++; $display("FAIL flush_redirect_kept c=%0d: v=%b id=%0d cmd=%h, want 1 0 c0de", c, fe_cmd_v, grant_id, fe_cmd);
            end
            tick();
        end
        ready = 1'b1;
        tick();
        @(negedge clk);
        tests_run++;
        if (fe_cmd_v !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL flush_redirect_done: v=%b busy=%b, want 0 0", fe_cmd_v, busy);
        end
        flush      = 1'b0;
        ready      = 1'b0;
        req_v      = 4'b0010;
        req_serial = 4'b0010;
        set_cmd(1, 64'hBEEF);
        tick();
        req_v      = 4'b0000;
        req_serial = 4'b0000;
        flush      = 1'b1;
        ready      = 1'b1;
        @(negedge clk);
        tests_run++;
        if (fe_cmd_v !== 1'b1 || grant_id !== 2'd1 || fe_cmd !== 64'hBEEF) begin
            tests_failed++; $display("FAIL flush_ready_issue: v=%b id=%0d cmd=%h, want 1 1 beef", fe_cmd_v, grant_id, fe_cmd);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || fe_cmd_v !== 1'b0) begin
            tests_failed++; $display("FAIL flush_ready_delivered: busy=%b v=%b, want 1 0", busy, fe_cmd_v);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        set_cmd(2, 64'h7777);
        req_v = 4'b0100;
        tick();
        req_v = 4'b0000;
        @(negedge clk);
        tests_run++;
        if (fe_cmd_v !== 1'b1 || fe_cmd !== 64'h7777) begin
            tests_failed++; $display("FAIL areset_pre: v=%b cmd=%h, want 1 7777", fe_cmd_v, fe_cmd);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (fe_cmd_v !== 1'b0 || busy !== 1'b0 || fe_cmd !== '0) begin
            tests_failed++; $display("FAIL areset_clear: v=%b busy=%b cmd=%h, want 0 0 0", fe_cmd_v, busy, fe_cmd);
        end
        tick();
        reset_n = 1'b1;
        req_v   = 4'b1110;
        @(negedge clk);
        tests_run++;
        if (req_yumi !== 4'b0010 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL areset_ptr: yumi=%b busy=%b, want 0010 0", req_yumi, busy);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        m_hold = 0; m_drain = 0; m_serial = 0; m_cmd = '0; m_id = 0; m_ptr = 1;
        for (int c = 0; c < 3000; c++) begin
            int           pick;
            logic [N-1:0] ey;
            for (int i = 0; i < N; i++) set_cmd(i, {$urandom, $urandom});
            req_v      = 4'($urandom);
            req_serial = 4'($urandom) & 4'($urandom);
            fence      = ($urandom % 2) == 0;
            ready      = ($urandom % 3) != 0;
            flush      = ($urandom % 6) == 0;
            @(negedge clk);
            pick = m_pick();
            ey   = (pick >= 0) ? 4'(1 << pick) : 4'b0;
            tests_run++;
            if (req_yumi !== ey || fe_cmd_v !== m_hold || busy !== (m_hold | m_drain) ||
                fe_cmd !== m_cmd || grant_id !== 2'(m_id)) begin
                tests_failed++;
                $display("FAIL random c=%0d: yumi=%b v=%b busy=%b cmd=%h id=%0d, want %b %b %b %h %0d",
                         c, req_yumi, fe_cmd_v, busy, fe_cmd, grant_id, ey, m_hold, m_hold | m_drain, m_cmd, m_id);
            end
            m_step(pick);
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        reset_n = 1'b0;
        req_cmd = '0;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_priority();
        test_serial_fence();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
